// File: rtl/blake2_msg_sched_if.sv
// Bundle of the BLAKE2 message-schedule control and beat stream.
// A beat transfers on every rising edge where out_valid_o and out_ready_i are both 1;
// while out_valid_o=1 and out_ready_i=0 the producer holds every beat field unchanged.
interface blake2_msg_sched_if #(
   parameter int WORD_W = 64,
   parameter int LANES  = 2
);
   logic                      start_i;
   logic [16*WORD_W-1:0]      m_i;
   logic                      out_ready_i;
   logic                      out_valid_o;
   logic [LANES*WORD_W-1:0]   out_words_o;
   logic [LANES*4-1:0]        out_idx_o;
   logic [3:0]                out_round_o;
   logic [3:0]                out_beat_o;
   logic                      out_last_o;
   logic                      busy_o;
   logic                      done_o;

   modport slave (
      input  start_i, m_i, out_ready_i,
      output out_valid_o, out_words_o, out_idx_o, out_round_o, out_beat_o,
             out_last_o, busy_o, done_o
   );

   modport master (
      output start_i, m_i, out_ready_i,
      input  out_valid_o, out_words_o, out_idx_o, out_round_o, out_beat_o,
             out_last_o, busy_o, done_o
   );
endinterface

// File: rtl/blake2_msg_sched.sv
// BLAKE2 message scheduler: captures a 16-word block and streams it permuted by SIGMA,
// LANES words per beat, for ROUNDS rounds. busy_o mirrors the FSM state (RUN).
module blake2_msg_sched #(
   parameter int ROUNDS = 12,
   parameter int WORD_W = 64,
   parameter int LANES  = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   blake2_msg_sched_if.slave    bus
);
   localparam int         BEATS      = 16 / LANES;
   localparam logic [3:0] LAST_BEAT  = 4'(BEATS - 1);
   localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [16*WORD_W-1:0]     r_msg;
   logic [3:0]               r_round;
   logic [3:0]               r_beat;
   logic                     r_done;
   logic                     w_valid;
   logic                     w_busy;
   logic                     w_start;
   logic                     w_hs;
   logic                     w_beat_wrap;
   logic                     w_last;
   logic [3:0]               w_row;
   logic [63:0]              w_row_bits;
   logic [3:0]               w_col;
   logic [3:0]               w_sel;
   logic [LANES*4-1:0]       w_idx;
   logic [LANES*WORD_W-1:0]  w_words;

   // Row entries packed as nibbles, column 0 in the least significant nibble.
   function automatic logic [63:0] sigma_row(input logic [3:0] row);
      logic [63:0] v;
      case (row)
         4'd1:    v = 64'h357B20C16DF984AE;
         4'd2:    v = 64'h491763EADF250C8B;
         4'd3:    v = 64'h8F04A562EBCD1397;
         4'd4:    v = 64'hD386CB1EFA427509;
         4'd5:    v = 64'h91EF57D438B0A6C2;
         4'd6:    v = 64'hB8293670A4DEF15C;
         4'd7:    v = 64'hA2684F05931CE7BD;
         4'd8:    v = 64'h5A417D2C803B9EF6;
         4'd9:    v = 64'h0DC3E9BF5167482A;
         default: v = 64'hFEDCBA9876543210;
      endcase
      return v;
   endfunction

   assign w_start     = (r_state == S_IDLE) && bus.start_i;
   assign w_hs        = (r_state == S_RUN) && bus.out_ready_i;
   assign w_beat_wrap = (r_beat == LAST_BEAT);
   assign w_last      = (r_state == S_RUN) && (r_round == LAST_ROUND) && w_beat_wrap;

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start_i) w_state_nxt = S_RUN;
         S_RUN:   if (w_hs && w_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_valid = (r_state == S_RUN);
      w_busy  = (r_state == S_RUN);
   end

   // Counters return to zero on completion so a reset-free restart begins cleanly.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_msg   <= '0;
         r_round <= '0;
         r_beat  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_hs && w_last;
         if (w_start) begin
            r_msg   <= bus.m_i;
            r_round <= '0;
            r_beat  <= '0;
         end else if (w_hs) begin
            if (w_last) begin
               r_round <= '0;
               r_beat  <= '0;
            end else if (w_beat_wrap) begin
               r_beat  <= '0;
               r_round <= r_round + 4'd1;
            end else begin
               r_beat  <= r_beat + 4'd1;
            end
         end
      end
   end

   assign w_row      = (r_round >= 4'd10) ? (r_round - 4'd10) : r_round;
   assign w_row_bits = sigma_row(w_row);

   always_comb begin
      w_idx   = '0;
      w_words = '0;
      w_col   = '0;
      w_sel   = '0;
      for (int k = 0; k < LANES; k++) begin
         w_col = 4'(int'(r_beat) * LANES + k);
         w_sel = w_row_bits[w_col*4 +: 4];
         w_idx[k*4 +: 4]             = w_sel;
         w_words[k*WORD_W +: WORD_W] = r_msg[w_sel*WORD_W +: WORD_W];
      end
      if (r_state == S_IDLE) begin
         w_idx   = '0;
         w_words = '0;
      end
   end

   assign bus.out_valid_o = w_valid;
   assign bus.busy_o      = w_busy;
   assign bus.done_o      = r_done;
   assign bus.out_last_o  = w_last;
   assign bus.out_round_o = w_valid ? r_round : 4'd0;
   assign bus.out_beat_o  = w_valid ? r_beat : 4'd0;
   assign bus.out_idx_o   = w_idx;
   assign bus.out_words_o = w_words;
endmodule

// File: tb/tb_blake2_msg_sched.sv
// Bench for blake2_msg_sched: a default (12 rounds, 64-bit, 2 lanes) instance and a
// BLAKE2s-style (10 rounds, 32-bit, 4 lanes) instance checked against a SIGMA model.
module tb_blake2_msg_sched;
   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   always #5 clk = ~clk;

   blake2_msg_sched_if #(.WORD_W(64), .LANES(2)) a_if ();
   blake2_msg_sched_if #(.WORD_W(32), .LANES(4)) b_if ();

   blake2_msg_sched #(.ROUNDS(12), .WORD_W(64), .LANES(2)) dut_a (
      .clk_i(clk), .rst_i(rst_a), .bus(a_if.slave));
   blake2_msg_sched #(.ROUNDS(10), .WORD_W(32), .LANES(4)) dut_b (
      .clk_i(clk), .rst_i(rst_b), .bus(b_if.slave));

   localparam int SIG [10][16] = '{
      '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
      '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
      '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
      '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
      '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
      '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
      '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
      '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
      '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
      '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
   };

   longint unsigned msg_a [16];
   longint unsigned msg_b [16];
   logic [159:0]    exp_q [$];
   int              n_cmp  = 0;
   int              n_fail = 0;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Packed beat: [152] last, [151:148] round, [147:144] beat, [143:128] idx, [127:0] words.
   function automatic logic [159:0] model(input bit sel, input int r, input int b);
      logic [159:0] v;
      int lanes, rounds, c, id;
      lanes  = sel ? 4 : 2;
      rounds = sel ? 10 : 12;
      v = '0;
      for (int k = 0; k < lanes; k++) begin
         c  = b * lanes + k;
         id = SIG[r % 10][c];
         v[128 + k*4 +: 4] = 4'(id);
         if (sel) v[k*32 +: 32] = msg_b[id][31:0];
         else     v[k*64 +: 64] = msg_a[id];
      end
      v[147:144] = 4'(b);
      v[151:148] = 4'(r);
      v[152]     = (r == rounds - 1) && (b == 16 / lanes - 1);
      return v;
   endfunction

   function automatic logic [159:0] obs_of(input bit sel);
      logic [159:0] v;
      if (sel) v = {7'b0, b_if.out_last_o, b_if.out_round_o, b_if.out_beat_o,
                    b_if.out_idx_o, b_if.out_words_o};
      else     v = {7'b0, a_if.out_last_o, a_if.out_round_o, a_if.out_beat_o,
                    8'b0, a_if.out_idx_o, a_if.out_words_o};
      return v;
   endfunction

   function automatic logic [2:0] status_of(input bit sel);
      if (sel) return {b_if.out_valid_o, b_if.busy_o, b_if.done_o};
      return {a_if.out_valid_o, a_if.busy_o, a_if.done_o};
   endfunction

   task automatic set_start(input bit sel, input logic v);
      if (sel) b_if.start_i = v;
      else     a_if.start_i = v;
   endtask

   task automatic set_ready(input bit sel, input logic v);
      if (sel) b_if.out_ready_i = v;
      else     a_if.out_ready_i = v;
   endtask

   task automatic load_msg(input bit sel, input bit alt);
      for (int j = 0; j < 16; j++) begin
         if (sel) b_if.m_i[j*32 +: 32] = alt ? ~msg_b[j][31:0] : msg_b[j][31:0];
         else     a_if.m_i[j*64 +: 64] = alt ? ~msg_a[j] : msg_a[j];
      end
   endtask

   // Driven at a negedge; expected beats are queued as the block is offered.
   task automatic start_block(input bit sel);
      logic [159:0] o;
      int rounds, beats;
      rounds = sel ? 10 : 12;
      beats  = sel ? 4 : 8;
      load_msg(sel, 1'b0);
      set_start(sel, 1'b1);
      for (int r = 0; r < rounds; r++)
         for (int b = 0; b < beats; b++)
            exp_q.push_back(model(sel, r, b));
      @(negedge clk);
      set_start(sel, 1'b0);
      chk("start_status", status_of(sel), 3'b110);
      o = obs_of(sel);
      chk("start_pos", o[151:144], 8'h00);
   endtask

   task automatic consume(input bit sel, input int stall_at, input int inject_at,
                          input bit rst_mid, input bit rand_ready, input bit b2b,
                          input bit directed);
      logic [159:0] o, snap, e;
      logic [2:0]   st;
      int hs, cyc, total, stall_cnt;
      bit rdy, aborted, inj_done;
      total = sel ? 40 : 96;
      hs = 0; cyc = 0; stall_cnt = 0; aborted = 0; inj_done = 0; snap = '0;
      while (hs < total && cyc < 3000 && !aborted) begin
         o  = obs_of(sel);
         st = status_of(sel);
         rdy = 1'b1;
         if (rand_ready) rdy = ($urandom_range(0, 2) != 0);
         if (hs == stall_at && stall_cnt < 5) begin
            if (stall_cnt == 0) snap = o;
            else                chk("stall_hold", o, snap);
            rdy = 1'b0;
            stall_cnt++;
         end
         set_start(sel, 1'b0);
         if (hs == inject_at && !inj_done) begin
            set_start(sel, 1'b1);
            load_msg(sel, 1'b1);
            inj_done = 1'b1;
         end
         set_ready(sel, rdy);
         if (rst_mid && st[2] && o[151:148] == 4'd3 && o[147:144] == 4'd2) begin
            if (sel) rst_b = 1'b1; else rst_a = 1'b1;
            @(negedge clk);
            rst_a = 1'b0; rst_b = 1'b0;
            chk("rst_status", status_of(sel), 3'b000);
            chk("rst_outs", obs_of(sel), '0);
            @(negedge clk);
            chk("rst_no_done", status_of(sel), 3'b000);
            exp_q.delete();
            aborted = 1'b1;
         end else begin
            if (st[2] && rdy) begin
               if (exp_q.size() == 0) begin
                  chk("queue_underflow", 160'(exp_q.size()), 160'd1);
                  e = '0;
               end else begin
                  e = exp_q.pop_front();
               end
               chk("beat", o, e);
               if (directed && !sel && (hs == 0 || hs == 80))
                  chk("row0_idx", o[135:128], 8'h10);
               if (directed && !sel && hs == 8) begin
                  chk("r1b0_idx", o[135:128], 8'hAE);
                  chk("r1b0_w0", o[63:0], 64'd14);
                  chk("r1b0_w1", o[127:64], 64'd10);
               end
               if (directed && sel && hs == 4) chk("s_r1b0_idx", o[143:128], 16'h84AE);
               if (directed && sel && hs == 39) chk("s_last", o[152:144], {1'b1, 4'd9, 4'd3});
               hs++;
            end
            @(negedge clk);
            cyc++;
         end
      end
      set_start(sel, 1'b0);
      set_ready(sel, 1'b1);
      if (!aborted) begin
         chk("hs_count", 160'(hs), 160'(total));
         chk("done_pulse", status_of(sel), 3'b001);
         chk("queue_empty", 160'(exp_q.size()), 160'd0);
         if (b2b) begin
            start_block(sel);
         end else begin
            @(negedge clk);
            chk("done_once", status_of(sel), 3'b000);
         end
      end
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      a_if.start_i = 1'b0; a_if.m_i = '0; a_if.out_ready_i = 1'b1;
      b_if.start_i = 1'b0; b_if.m_i = '0; b_if.out_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_status_a", status_of(1'b0), 3'b000);
      chk("reset_outs_a", obs_of(1'b0), '0);
      chk("reset_status_b", status_of(1'b1), 3'b000);
      // start_i while reset is held must be ignored
      a_if.start_i = 1'b1;
      @(negedge clk);
      chk("reset_prio", status_of(1'b0), 3'b000);
      a_if.start_i = 1'b0;
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);

      for (int j = 0; j < 16; j++) msg_a[j] = longint'(j);
      start_block(1'b0);
      for (int j = 0; j < 16; j++) msg_a[j] = {$urandom(), $urandom()};
      consume(1'b0, 20, 40, 1'b0, 1'b0, 1'b1, 1'b1);

      consume(1'b0, -1, -1, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int j = 0; j < 16; j++) msg_a[j] = {$urandom(), $urandom()};
      start_block(1'b0);
      consume(1'b0, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0);

      for (int j = 0; j < 16; j++) msg_b[j] = longint'($urandom());
      start_block(1'b1);
      consume(1'b1, -1, -1, 1'b0, 1'b1, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/blake2_msg_sched.md
BLAKE2_MSG_SCHED -- requirements
Module: blake2_msg_sched

Interface
REQ-001 SHALL have parameter ROUNDS, default 12: number of rounds scheduled; legal range 1..16 (12 = BLAKE2b, 10 = BLAKE2s).
REQ-002 SHALL have parameter WORD_W, default 64: message word width in bits (64 = BLAKE2b, 32 = BLAKE2s).
REQ-003 SHALL have parameter LANES, default 2: message words emitted per beat; legal values 1, 2, 4, 8, 16.
REQ-004 SHALL run on one clock; reset is synchronous and active-high.
REQ-005 clk_i  in  1  clock; all state changes on its rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 start_i  in  1  start request; sampled only in IDLE.
REQ-008 m_i  in  16*WORD_W  message block; word j = m_i[j*WORD_W +: WORD_W].
REQ-009 out_ready_i  in  1  consumer ready.
REQ-010 out_valid_o  out  1  beat valid.
REQ-011 out_words_o  out  LANES*WORD_W  lane k = out_words_o[k*WORD_W +: WORD_W].
REQ-012 out_idx_o  out  LANES*4  lane k = message index used for lane k.
REQ-013 out_round_o  out  4  current round number, 0..ROUNDS-1.
REQ-014 out_beat_o  out  4  beat number within the round, 0..16/LANES-1.
REQ-015 out_last_o  out  1  final beat of the final round.
REQ-016 busy_o  out  1  high in RUN.
REQ-017 done_o  out  1  one-cycle pulse on completion.

Function
REQ-018 SHALL implement a two-state FSM, IDLE and RUN.
REQ-019 SHALL hold the standard BLAKE2 SIGMA permutation table, rows 0..9, internally; round r SHALL use row r mod 10, so rounds 10 and 11 reuse rows 0 and 1.
REQ-020 In IDLE with start_i=1, SHALL capture all 16 words of m_i into an internal register, clear round and beat to 0, and enter RUN on the next edge.
REQ-021 Latency: out_valid_o SHALL be 1 on the first cycle after start_i is accepted; out_valid_o SHALL equal 1 for the whole of RUN and 0 in IDLE.
REQ-022 For beat b of round r, lane k SHALL use column c = b*LANES+k; out_idx_o lane k = SIGMA[r mod 10][c]; out_words_o lane k = captured word at that index.
REQ-023 out_words_o, out_idx_o, out_round_o, out_beat_o and out_last_o SHALL be registered or derived only from registered state, and SHALL stay stable while out_valid_o=1 and out_ready_i=0.
REQ-024 A handshake (out_valid_o & out_ready_i) SHALL advance the beat; when the beat wraps from 16/LANES-1 to 0, the round SHALL increment.
REQ-025 out_last_o SHALL be 1 only when round = ROUNDS-1 and beat = 16/LANES-1.
REQ-026 A handshake with out_last_o=1 SHALL return the FSM to IDLE and assert done_o for exactly the next cycle.
REQ-027 start_i SHALL be ignored in RUN, and changes on m_i after capture SHALL not affect the outputs.
REQ-028 start_i asserted on the same cycle that done_o is high (FSM in IDLE) SHALL be accepted normally, allowing back-to-back blocks with one idle cycle.
REQ-029 A block SHALL complete in exactly ROUNDS*16/LANES handshakes.
REQ-030 When LANES=16, out_beat_o SHALL be constantly 0 and every handshake SHALL advance the round.

Reset
REQ-031 rst_i=1 SHALL force IDLE, with out_valid_o=0, busy_o=0, done_o=0, out_last_o=0, out_round_o=0, out_beat_o=0, out_idx_o=0 and out_words_o=0; rst_i SHALL take priority over start_i and over a handshake on the same edge.
REQ-032 Reset during RUN SHALL abort the block without asserting done_o; the next start_i after reset SHALL begin again at round 0, beat 0.

Verification
REQ-033 Defaults, m_i word j = j, out_ready_i held at 1: 96 beats follow; beat 0 of round 0 gives idx {0,1}; round 1 beat 0 gives idx {14,10} and words {14,10}; round 10 beat 0 gives idx {0,1}; done_o pulses after beat 96.
REQ-034 Backpressure: drop out_ready_i for 5 cycles mid-round -> all outputs are held constant; the sequence resumes with no beat skipped or duplicated.
REQ-035 ROUNDS=10, WORD_W=32, LANES=4: round 1 beat 0 gives idx {14,10,4,8}; out_last_o appears on round 9 beat 3; 40 handshakes in total.
REQ-036 Pulse start_i during RUN while driving a new m_i -> ignored; the outputs continue to use the captured block.
REQ-037 Assert rst_i on round 3 beat 2 -> the next cycle shows out_valid_o=0 and busy_o=0, with no done_o pulse; a new start runs the full 96 beats.
REQ-038 Assert start_i on the done_o cycle -> the second block is accepted and out_valid_o rises on the following cycle with round 0, beat 0.
